dma_cpu_port: RTL and testbench
===============================

Name: dma_cpu_port

Overview:
- CPU-side program interface of the 8237A-compatible DMA controller.
- Samples the 8237 bus pins (CS_N, IOR_N, IOW_N, A[3:0], DB) while the controller is idle.
- Decodes each completed write into single-cycle register-file write strobes. Serves reads from the register-file contents.
- Owns the byte-pointer flip-flop for 16-bit address/word-count access, and sequences master clear, clear-byte-pointer and clear-mask commands.

Parameters:
- NCH, 4, number of DMA channels (address map is fixed for 4).
- AW, 16, address/word-count register width (two bytes).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- CS_N  in  1  chip select, active low.
- IOR_N  in  1  CPU read strobe, active low.
- IOW_N  in  1  CPU write strobe, active low.
- A  in  4  register address A3..A0.
- DB_IN  in  8  data bus from CPU.
- DB_OUT  out  8  read data to CPU.
- dbOe  out  1  data bus output enable.
- HLDA  in  1  hold acknowledge; 1 = DMA owns bus, program port disabled.
- currAddr  in  NCH*AW  current address registers, channel n at [n*16+:16].
- currWord  in  NCH*AW  current word-count registers, same packing.
- statusIn  in  8  status register.
- tempIn  in  8  temporary register.
- wrData  out  8  byte to be written, valid with any strobe.
- wrHi  out  1  0 = low byte, 1 = high byte (channel-register strobes only).
- wrAddr  out  NCH  base+current address write strobe per channel.
- wrWord  out  NCH  base+current word-count write strobe per channel.
- wrCommand, wrMode, wrRequest, wrSingleMask, wrAllMask  out  1 each  register write strobes.
- clearMask  out  1  clear-mask-register command strobe.
- masterClear  out  1  master-clear command strobe.
- statusRdClr  out  1  pulse: status was read, clear TC bits [3:0].
- bytePtr  out  1  byte-pointer flip-flop (observability).

Behaviour:
- Reset: all outputs 0, including DB_OUT=0x00, dbOe=0, bytePtr=0, and all strobes and pipeline stages.
- Input sampling:
  - Stage s1 registers CS_N, IOR_N, IOW_N, A, DB_IN every CLK; s2 registers s1.
  - Access qualified = s1 CS_N=0, HLDA=0, and exactly one of IOR_N/IOW_N low.
- Write hold: on every CLK where the qualified write is active in s1, latch A and DB_IN into hold registers.
- Write commit:
  - Trigger: s2 IOW_N=0 and s1 IOW_N=1, with the hold valid.
  - Strobe timing: strobe registered at the next edge, high exactly one cycle. This is the 2nd CLK edge after IOW_N is first sampled high.
  - wrData = held byte.
- Write decode, by held address:
  - 0x0/2/4/6: wrAddr[a>>1], wrHi=bytePtr, then bytePtr toggles.
  - 0x1/3/5/7: wrWord[a>>1], wrHi=bytePtr, then bytePtr toggles.
  - 0x8 wrCommand; 0x9 wrRequest; 0xA wrSingleMask; 0xB wrMode.
  - 0xC: bytePtr<=0, no strobe.
  - 0xD: masterClear, bytePtr<=0.
  - 0xE: clearMask.
  - 0xF: wrAllMask.
- Read:
  - While the qualified read is active in s1: DB_OUT and dbOe=1 registered, so 2-cycle latency from pin assertion. Read data updates every cycle.
  - Deasserting the read (or losing qualification) clears dbOe at the next edge. DB_OUT holds its last value.
- Read mux:
  - 0x0-0x7: low or high byte of currAddr/currWord per bytePtr.
  - 0x8: statusIn.
  - 0xD: tempIn.
  - All other addresses: 0x00.
- Read completion:
  - Trigger: s2 IOR_N=0 and s1 IOR_N=1, with the access qualified in s2.
  - Address 0x0-0x7: bytePtr toggles at the next edge.
  - Address 0x8: statusRdClr pulses one cycle.
- Boundaries:
  - IOR_N and IOW_N both low: not qualified; no dbOe, no hold update. A trailing edge from that state commits nothing.
  - HLDA rises during an access: the access is aborted and its hold is invalidated. The later trailing edge commits nothing, bytePtr is unchanged, and dbOe drops the next edge.
  - CS_N rising before IOW_N: commit still uses the last qualified hold. Only edges where a hold exists commit.
  - Back-to-back accesses with 1 CLK of strobe high: each completes independently.
  - bytePtr wraps 1->0 by toggling.
  - Master clear and 0xC override any toggle in the same cycle.
  - RESET mid-access: all state cleared. The pending edge is lost because s1/s2 reset to "inactive". Reset values of s1/s2 are strobes=1, CS_N=1.

Test Plan:
- Ch2 base address write: IOW to A=0x4 with 0x34, then 0x12 -> wrAddr=4'b0100 with wrHi=0/wrData=0x34, then wrHi=1/wrData=0x12; bytePtr ends 0.
- Read back: currAddr ch1=0xBEEF, two IOR to A=0x2 -> DB_OUT 0xEF then 0xBE, dbOe 2 cycles after IOR_N low; bytePtr toggles twice.
- Byte-pointer clear: write A=0x1 (bytePtr->1), write A=0xC, write A=0x1 with 0x55 -> final strobe wrWord[0] with wrHi=0.
- Status read: statusIn=0x0F, IOR A=0x8 -> DB_OUT=0x0F, statusRdClr one pulse after IOR_N rises; bytePtr unchanged.
- Abort/illegal: HLDA rises mid-IOW to A=0x0 -> no strobe, bytePtr unchanged. IOR_N and IOW_N both low -> dbOe stays 0, no strobes.
- Master clear and reset: write A=0xD with bytePtr=1 -> masterClear pulse, bytePtr=0. RESET asserted while IOW_N low then released -> no strobe, all outputs 0.

Source files
------------

// File: rtl/dma_cpu_port.sv
// CPU program port of an 8237A-style DMA controller: samples the bus pins,
// turns completed writes into one-cycle register strobes, serves reads, owns bytePtr.
module dma_cpu_port #(
    parameter int NCH = 4,
    parameter int AW  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CS_N,
    input  logic              IOR_N,
    input  logic              IOW_N,
    input  logic [3:0]        A,
    input  logic [7:0]        DB_IN,
    output logic [7:0]        DB_OUT,
    output logic              dbOe,
    input  logic              HLDA,
    input  logic [NCH*AW-1:0] currAddr,
    input  logic [NCH*AW-1:0] currWord,
    input  logic [7:0]        statusIn,
    input  logic [7:0]        tempIn,
    output logic [7:0]        wrData,
    output logic              wrHi,
    output logic [NCH-1:0]    wrAddr,
    output logic [NCH-1:0]    wrWord,
    output logic              wrCommand,
    output logic              wrMode,
    output logic              wrRequest,
    output logic              wrSingleMask,
    output logic              wrAllMask,
    output logic              clearMask,
    output logic              masterClear,
    output logic              statusRdClr,
    output logic              bytePtr
);

    logic          r_s1_cs_n, r_s1_ior_n, r_s1_iow_n;
    logic [3:0]    r_s1_a;
    logic [7:0]    r_s1_db;
    logic          r_s2_ior_n, r_s2_iow_n, r_s2_qrd;
    logic [3:0]    r_s2_a;
    logic          r_hold_vld;
    logic [3:0]    r_hold_a;
    logic [7:0]    r_hold_d;
    logic          r_bp;

    logic          w_qual, w_qrd, w_qwr;
    logic          w_commit, w_rd_done, w_bp_tog, w_bp_clr;
    logic [1:0]    w_wch;
    logic [AW-1:0] w_reg;
    logic [7:0]    w_rd_byte;

    assign w_qual    = !r_s1_cs_n && !HLDA && (r_s1_ior_n ^ r_s1_iow_n);
    assign w_qrd     = w_qual && !r_s1_ior_n;
    assign w_qwr     = w_qual && !r_s1_iow_n;
    assign w_commit  = !r_s2_iow_n && r_s1_iow_n && r_hold_vld;
    assign w_rd_done = !r_s2_ior_n && r_s1_ior_n && r_s2_qrd;
    assign w_bp_clr  = w_commit && (r_hold_a == 4'hC || r_hold_a == 4'hD);
    assign w_bp_tog  = (w_commit && !r_hold_a[3]) ^ (w_rd_done && !r_s2_a[3]);
    assign w_wch     = r_hold_a[2:1];
    assign bytePtr   = r_bp;

    always_comb begin
        w_reg     = r_s1_a[0] ? currWord[int'(r_s1_a[2:1])*AW +: AW]
                              : currAddr[int'(r_s1_a[2:1])*AW +: AW];
        w_rd_byte = 8'h00;
        if (!r_s1_a[3])
            w_rd_byte = r_bp ? w_reg[15:8] : w_reg[7:0];
        else if (r_s1_a == 4'h8)
            w_rd_byte = statusIn;
        else if (r_s1_a == 4'hD)
            w_rd_byte = tempIn;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s1_cs_n    <= 1'b1;
            r_s1_ior_n   <= 1'b1;
            r_s1_iow_n   <= 1'b1;
            r_s1_a       <= 4'h0;
            r_s1_db      <= 8'h00;
            r_s2_ior_n   <= 1'b1;
            r_s2_iow_n   <= 1'b1;
            r_s2_qrd     <= 1'b0;
            r_s2_a       <= 4'h0;
            r_hold_vld   <= 1'b0;
            r_hold_a     <= 4'h0;
            r_hold_d     <= 8'h00;
            r_bp         <= 1'b0;
            DB_OUT       <= 8'h00;
            dbOe         <= 1'b0;
            wrData       <= 8'h00;
            wrHi         <= 1'b0;
            wrAddr       <= '0;
            wrWord       <= '0;
            wrCommand    <= 1'b0;
            wrMode       <= 1'b0;
            wrRequest    <= 1'b0;
            wrSingleMask <= 1'b0;
            wrAllMask    <= 1'b0;
            clearMask    <= 1'b0;
            masterClear  <= 1'b0;
            statusRdClr  <= 1'b0;
        end else begin
            r_s1_cs_n  <= CS_N;
            r_s1_ior_n <= IOR_N;
            r_s1_iow_n <= IOW_N;
            r_s1_a     <= A;
            r_s1_db    <= DB_IN;
            r_s2_ior_n <= r_s1_ior_n;
            r_s2_iow_n <= r_s1_iow_n;
            r_s2_qrd   <= w_qrd;
            r_s2_a     <= r_s1_a;

            // A hold is consumed by its commit and killed by HLDA or a read/write collision
            if (HLDA || (!r_s1_ior_n && !r_s1_iow_n) || w_commit)
                r_hold_vld <= 1'b0;
            if (w_qwr) begin
                r_hold_vld <= 1'b1;
                r_hold_a   <= r_s1_a;
                r_hold_d   <= r_s1_db;
            end

            dbOe <= w_qrd;
            if (w_qrd)
                DB_OUT <= w_rd_byte;

            wrHi         <= 1'b0;
            wrAddr       <= '0;
            wrWord       <= '0;
            wrCommand    <= 1'b0;
            wrMode       <= 1'b0;
            wrRequest    <= 1'b0;
            wrSingleMask <= 1'b0;
            wrAllMask    <= 1'b0;
            clearMask    <= 1'b0;
            masterClear  <= 1'b0;
            statusRdClr  <= w_rd_done && (r_s2_a == 4'h8);

            if (w_commit) begin
                wrData <= r_hold_d;
                if (!r_hold_a[3]) begin
                    wrHi <= r_bp;
                    if (r_hold_a[0])
                        wrWord[w_wch] <= 1'b1;
                    else
                        wrAddr[w_wch] <= 1'b1;
                end else begin
                    case (r_hold_a[2:0])
                        3'd0:    wrCommand    <= 1'b1;
                        3'd1:    wrRequest    <= 1'b1;
                        3'd2:    wrSingleMask <= 1'b1;
                        3'd3:    wrMode       <= 1'b1;
                        3'd5:    masterClear  <= 1'b1;
                        3'd6:    clearMask    <= 1'b1;
                        3'd7:    wrAllMask    <= 1'b1;
                        default: ;
                    endcase
                end
            end

            if (w_bp_clr)
                r_bp <= 1'b0;
            else if (w_bp_tog)
                r_bp <= ~r_bp;
        end
    end

endmodule

// File: tb/tb_dma_cpu_port.sv
// Bench for dma_cpu_port: bus-cycle tasks feed a transaction-level model whose
// expected strobes and read bytes are queued and checked by an independent monitor.
module tb_dma_cpu_port;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CS_N = 1'b1, IOR_N = 1'b1, IOW_N = 1'b1, HLDA = 1'b0;
    logic [3:0]  A = 4'h0;
    logic [7:0]  DB_IN = 8'h00;
    logic [63:0] currAddr = '0, currWord = '0;
    logic [7:0]  statusIn = 8'h00, tempIn = 8'h00;
    logic [7:0]  DB_OUT, wrData;
    logic        dbOe, wrHi, bytePtr;
    logic [3:0]  wrAddr, wrWord;
    logic        wrCommand, wrMode, wrRequest, wrSingleMask, wrAllMask;
    logic        clearMask, masterClear, statusRdClr;

    dma_cpu_port #(.NCH(4), .AW(16)) dut (
        .CLK(CLK), .RESET(RESET), .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
        .A(A), .DB_IN(DB_IN), .DB_OUT(DB_OUT), .dbOe(dbOe), .HLDA(HLDA),
        .currAddr(currAddr), .currWord(currWord), .statusIn(statusIn), .tempIn(tempIn),
        .wrData(wrData), .wrHi(wrHi), .wrAddr(wrAddr), .wrWord(wrWord),
        .wrCommand(wrCommand), .wrMode(wrMode), .wrRequest(wrRequest),
        .wrSingleMask(wrSingleMask), .wrAllMask(wrAllMask), .clearMask(clearMask),
        .masterClear(masterClear), .statusRdClr(statusRdClr), .bytePtr(bytePtr)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [24:0] v;
        logic [24:0] m;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] rd_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic       m_bp = 1'b0;

    logic        any_strobe;
    logic [24:0] got_ev;
    assign any_strobe = |{wrAddr, wrWord, wrCommand, wrMode, wrRequest, wrSingleMask,
                          wrAllMask, clearMask, masterClear, statusRdClr};
    assign got_ev = {wrAddr, wrWord, wrCommand, wrMode, wrRequest, wrSingleMask,
                     wrAllMask, clearMask, masterClear, statusRdClr, wrHi, wrData};

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Strobe vector order: wrAddr[3:0], wrWord[3:0], cmd, mode, req, smask, amask, clrmask, mclr, srclr
    function automatic ev_t wr_ev(input logic [3:0] a, input logic [7:0] d, input logic bp);
        logic [15:0] s;
        logic        hi_m;
        s    = '0;
        hi_m = 1'b0;
        if (a < 4'h8) begin
            hi_m = 1'b1;
            if (a[0]) s[8 + int'(a[2:1])] = 1'b1;
            else      s[12 + int'(a[2:1])] = 1'b1;
        end else begin
            case (a)
                4'h8: s[7] = 1'b1;
                4'h9: s[5] = 1'b1;
                4'hA: s[4] = 1'b1;
                4'hB: s[6] = 1'b1;
                4'hD: s[1] = 1'b1;
                4'hE: s[2] = 1'b1;
                4'hF: s[3] = 1'b1;
                default: ;
            endcase
        end
        wr_ev.v = {s, bp & hi_m, d};
        wr_ev.m = {16'hFFFF, hi_m, 8'hFF};
    endfunction

    function automatic logic [7:0] rd_exp(input logic [3:0] a, input logic bp);
        logic [15:0] r16;
        rd_exp = 8'h00;
        if (a < 4'h8) begin
            r16    = a[0] ? currWord[int'(a[2:1])*16 +: 16] : currAddr[int'(a[2:1])*16 +: 16];
            rd_exp = bp ? r16[15:8] : r16[7:0];
        end else if (a == 4'h8) rd_exp = statusIn;
        else if (a == 4'hD)     rd_exp = tempIn;
    endfunction

    task automatic idle(input int n);
        @(negedge CLK);
        CS_N = 1'b1;
        repeat (n - 1) @(negedge CLK);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input int hold,
                      input bit cs_early, input bit timed);
        @(negedge CLK);
        A = a; DB_IN = d; CS_N = 1'b0; IOW_N = 1'b0;
        if (a != 4'hC) ev_q.push_back(wr_ev(a, d, m_bp));
        if (a < 4'h8) m_bp = ~m_bp;
        else if (a == 4'hC || a == 4'hD) m_bp = 1'b0;
        repeat (hold) @(negedge CLK);
        if (cs_early) begin
            CS_N = 1'b1;
            @(negedge CLK);
        end
        IOW_N = 1'b1;
        if (timed) begin
            @(posedge CLK); #1;
            chk("strobe_early", any_strobe, 0);
            @(posedge CLK); #1;
            chk("strobe_timing", any_strobe, (a != 4'hC));
        end
    endtask

    task automatic rd(input logic [3:0] a, input bit abort);
        @(negedge CLK);
        A = a; CS_N = 1'b0; IOR_N = 1'b0;
        rd_q.push_back(rd_exp(a, m_bp));
        @(posedge CLK); #1;
        chk("dbOe_lat1", dbOe, 0);
        @(posedge CLK); #1;
        chk("dbOe_lat2", dbOe, 1);
        if (abort) begin
            @(negedge CLK);
            HLDA = 1'b1;
            @(posedge CLK); #1;
            chk("dbOe_hlda", dbOe, 0);
        end
        repeat (2) @(negedge CLK);
        IOR_N = 1'b1;
        if (abort) begin
            repeat (2) @(negedge CLK);
            HLDA = 1'b0;
        end else begin
            if (a < 4'h8) m_bp = ~m_bp;
            if (a == 4'h8) ev_q.push_back('{v: {16'h0001, 9'h0}, m: {16'hFFFF, 9'h0}});
        end
    endtask

    task automatic chk_bp(input string nm);
        chk(nm, bytePtr, m_bp);
    endtask

    // Monitor: pops an expectation whenever the DUT shows a strobe or starts driving the bus
    initial begin
        logic prev_oe;
        ev_t  e;
        prev_oe = 1'b0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                prev_oe = 1'b0;
            end else begin
                if (any_strobe) begin
                    if (ev_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL strobe_unexpected: got %0h required none at %0t", got_ev, $time);
                    end else begin
                        e = ev_q.pop_front();
                        chk("strobe_event", got_ev & e.m, e.v & e.m);
                    end
                end
                if (dbOe && !prev_oe) begin
                    if (rd_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL read_unexpected: got %0h required none at %0t", DB_OUT, $time);
                    end else begin
                        chk("read_data", DB_OUT, rd_q.pop_front());
                    end
                end
                prev_oe = dbOe;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ra;
        int         op;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK); #1;
        chk("reset_out_a", {DB_OUT, dbOe, wrData, wrHi, bytePtr}, 0);
        chk("reset_out_b", {wrAddr, wrWord, any_strobe}, 0);
        idle(2);

        // Channel 2 base address, low then high byte
        wr(4'h4, 8'h34, 3, 0, 1); idle(3);
        wr(4'h4, 8'h12, 3, 0, 1); idle(3);
        chk_bp("bp_after_ch2");

        // Read back channel 1 address
        currAddr[31:16] = 16'hBEEF;
        rd(4'h2, 0); idle(3); chk_bp("bp_rd1");
        rd(4'h2, 0); idle(3); chk_bp("bp_rd2");

        // Byte-pointer clear
        wr(4'h1, 8'hA1, 3, 0, 1); idle(3); chk_bp("bp_set");
        wr(4'hC, 8'h00, 3, 0, 1); idle(3); chk_bp("bp_clr");
        wr(4'h1, 8'h55, 3, 0, 1); idle(3);

        // Status read
        statusIn = 8'h0F;
        rd(4'h8, 0); idle(3); chk_bp("bp_status");

        // HLDA aborts a write
        @(negedge CLK); A = 4'h0; DB_IN = 8'h99; CS_N = 1'b0; IOW_N = 1'b0;
        repeat (2) @(negedge CLK); HLDA = 1'b1;
        repeat (2) @(negedge CLK); IOW_N = 1'b1;
        repeat (2) begin @(posedge CLK); #1; chk("strobe_hlda", any_strobe, 0); end
        @(negedge CLK); HLDA = 1'b0;
        idle(3); chk_bp("bp_hlda_wr");

        // HLDA aborts a read
        rd(4'h3, 1); idle(3); chk_bp("bp_hlda_rd");

        // IOR_N and IOW_N both low
        @(negedge CLK); A = 4'h0; DB_IN = 8'hAA; CS_N = 1'b0; IOR_N = 1'b0; IOW_N = 1'b0;
        repeat (3) begin @(posedge CLK); #1; chk("dbOe_bothlow", dbOe, 0); end
        @(negedge CLK); IOR_N = 1'b1; IOW_N = 1'b1;
        repeat (3) begin @(posedge CLK); #1; chk("strobe_bothlow", any_strobe, 0); end
        idle(3); chk_bp("bp_bothlow");

        // CS_N released before IOW_N, then back-to-back writes
        wr(4'h6, 8'h61, 3, 1, 1); idle(3);
        wr(4'h7, 8'h71, 2, 0, 0);
        wr(4'hB, 8'hB1, 2, 0, 1); idle(3);
        chk_bp("bp_b2b");

        // Master clear with bytePtr set
        if (!m_bp) begin wr(4'h3, 8'h33, 3, 0, 1); idle(3); end
        chk_bp("bp_pre_mclr");
        wr(4'hD, 8'h00, 3, 0, 1); idle(3);
        chk_bp("bp_mclr");

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            if (i % 8 == 0) begin
                currAddr = {$urandom(), $urandom()};
                currWord = {$urandom(), $urandom()};
                statusIn = 8'($urandom());
                tempIn   = 8'($urandom());
            end
            ra = 4'($urandom_range(0, 15));
            op = $urandom_range(0, 2);
            if (op == 0) begin
                wr(ra, 8'($urandom()), $urandom_range(1, 4), ($urandom_range(0, 3) == 0), 1);
            end else if (op == 1) begin
                rd(ra, 0);
            end else begin
                wr(ra, 8'($urandom()), 2, 0, 0);
                wr(4'($urandom_range(0, 15)), 8'($urandom()), 2, 0, 1);
            end
            idle(3);
            chk_bp("bp_random");
        end

        // Reset in the middle of a write
        wr(4'h5, 8'h5A, 3, 0, 1); idle(3);
        @(negedge CLK); A = 4'h4; DB_IN = 8'h77; CS_N = 1'b0; IOW_N = 1'b0;
        repeat (3) @(negedge CLK); RESET = 1'b1;
        repeat (2) @(negedge CLK); IOW_N = 1'b1; CS_N = 1'b1;
        @(negedge CLK); RESET = 1'b0; m_bp = 1'b0;
        repeat (4) begin @(posedge CLK); #1; chk("strobe_after_reset", any_strobe, 0); end
        chk("reset_mid_a", {DB_OUT, dbOe, wrData, wrHi, bytePtr}, 0);
        chk("reset_mid_b", {wrAddr, wrWord}, 0);

        idle(4);
        chk("ev_q_empty", ev_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
